// File: rtl/arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module arb_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store port.
// state  | meaning
// IDLE   | no access in flight; arbitration evaluated this cycle
// GNT_IF | fetch transaction owns the memory
// GNT_D  | load/store transaction owns the memory
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              LAT_W      = $clog2(MEM_LAT_MAX) + 1;
    localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LAT - 1);
    localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e        state;
    arb_state_e        next_state;
    logic              grant_d;
    logic              grant_if;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_zero;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;

    // Data wins unless fetch has been passed over STARVE_MAX times in a row.
    assign grant_d  = (state == IDLE) && d_req && !(if_req && (starve_cnt == STARVE_LIM));
    assign grant_if = (state == IDLE) && !grant_d && if_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = GNT_D;
                end else if (grant_if) begin
                    next_state = GNT_IF;
                end
            end
            GNT_IF, GNT_D: begin
                if (lat_zero) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    arb_lat_counter #(
        .W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_d || grant_if),
        .load_val (LAT_LOAD),
        .dec      (state != IDLE),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    // Fetch grants leave wdata untouched; it is never written for a fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            size_q  <= SZ_WORD;
        end else if (grant_d) begin
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            size_q  <= d_size;
        end else if (grant_if) begin
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (grant_if) begin
            starve_cnt <= '0;
        end
    end

    always_comb begin
        mem_en    = (state != IDLE);
        mem_we    = (state == GNT_D) && we_q && (lat_cnt == LAT_LOAD);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_size  = size_q;
        if_valid  = (state == GNT_IF) && lat_zero;
        d_valid   = (state == GNT_D) && lat_zero;
        // Read data is a pass-through, forced to zero while reset is held.
        if_rdata  = rst ? mem_rdata : '0;
        d_rdata   = rst ? mem_rdata : '0;
        if_stall  = if_req && !if_valid;
        d_stall   = d_req && !d_valid;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT = 1, 2, 3) share the same stimulus.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] if_rdata  [3];
    logic        if_valid  [3];
    logic        if_stall  [3];
    logic [31:0] d_rdata   [3];
    logic        d_valid   [3];
    logic        d_stall   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [1:0]  mem_size  [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_mem_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (g + 1),
            .STARVE_MAX (4)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata[g]),
            .if_valid  (if_valid[g]),
            .if_stall  (if_stall[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_size    (d_size),
            .d_rdata   (d_rdata[g]),
            .d_valid   (d_valid[g]),
            .d_stall   (d_stall[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_size  (mem_size[g]),
            .mem_rdata (mem_rdata)
        );
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        total_cnt++; if (mem_en[0] !== 1'b0) $display("FAIL reset_mem_en got %b want 0", mem_en[0]); else pass_cnt++;
        total_cnt++; if (if_valid[0] !== 1'b0) $display("FAIL reset_if_valid got %b want 0", if_valid[0]); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr[0]); else pass_cnt++;
        total_cnt++; if (if_rdata[0] !== 32'h0) $display("FAIL reset_if_rdata got %h want 0", if_rdata[0]); else pass_cnt++;
        total_cnt++; if (if_stall[0] !== 1'b1) $display("FAIL reset_if_stall got %b want 1", if_stall[0]); else pass_cnt++;
        total_cnt++; if (d_stall[0] !== 1'b0) $display("FAIL reset_d_stall got %b want 0", d_stall[0]); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h00A0_0093;
        #1;
        total_cnt++; if (if_stall[0] !== 1'b1) $display("FAIL fetch_c0_stall got %b want 1", if_stall[0]); else pass_cnt++;
        total_cnt++; if (mem_en[0] !== 1'b0) $display("FAIL fetch_c0_mem_en got %b want 0", mem_en[0]); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mem_en[0] !== 1'b1) $display("FAIL fetch_c1_mem_en got %b want 1", mem_en[0]); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 32'h10) $display("FAIL fetch_c1_addr got %h want 10", mem_addr[0]); else pass_cnt++;
        total_cnt++; if (mem_size[0] !== 2'b00) $display("FAIL fetch_c1_size got %b want 00", mem_size[0]); else pass_cnt++;
        total_cnt++; if (if_valid[0] !== 1'b1) $display("FAIL fetch_c1_valid got %b want 1", if_valid[0]); else pass_cnt++;
        total_cnt++; if (if_rdata[0] !== 32'h00A0_0093) $display("FAIL fetch_c1_rdata got %h want 00a00093", if_rdata[0]); else pass_cnt++;
        total_cnt++; if (if_stall[0] !== 1'b0) $display("FAIL fetch_c1_stall got %b want 0", if_stall[0]); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mem_en[0] !== 1'b0) $display("FAIL fetch_c2_mem_en got %b want 0", mem_en[0]); else pass_cnt++;
        total_cnt++; if (if_valid[0] !== 1'b0) $display("FAIL fetch_c2_valid got %b want 0", if_valid[0]); else pass_cnt++;
        total_cnt++; if (if_stall[0] !== 1'b1) $display("FAIL fetch_c2_stall got %b want 1", if_stall[0]); else pass_cnt++;
        total_cnt++; if (mem_addr[0] !== 32'h10) $display("FAIL fetch_c2_addr_hold got %h want 10", mem_addr[0]); else pass_cnt++;
        if_req = 1'b0;
        do_reset();
    endtask

    task automatic test_collision();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_size = 2'b00;
        mem_rdata = 32'h1111_2222;
        #1;
        total_cnt++; if (if_stall[1] !== 1'b1) $display("FAIL coll_c0_if_stall got %b want 1", if_stall[1]); else pass_cnt++;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            total_cnt++;
            if (d_valid[1] !== (cyc == 2)) $display("FAIL coll_c%0d_d_valid got %b want %b", cyc, d_valid[1], cyc == 2); else pass_cnt++;
            total_cnt++;
            if (if_valid[1] !== (cyc == 5)) $display("FAIL coll_c%0d_if_valid got %b want %b", cyc, if_valid[1], cyc == 5); else pass_cnt++;
            total_cnt++;
            if (mem_en[1] !== (cyc == 1 || cyc == 2 || cyc == 4 || cyc == 5))
                $display("FAIL coll_c%0d_mem_en got %b want %b", cyc, mem_en[1], cyc == 1 || cyc == 2 || cyc == 4 || cyc == 5);
            else pass_cnt++;
            total_cnt++;
            if (if_stall[1] !== (cyc <= 4)) $display("FAIL coll_c%0d_if_stall got %b want %b", cyc, if_stall[1], cyc <= 4); else pass_cnt++;
            if (cyc == 1) begin
                total_cnt++; if (mem_addr[1] !== 32'h100) $display("FAIL coll_d_addr got %h want 100", mem_addr[1]); else pass_cnt++;
            end
            if (cyc == 2) begin
                total_cnt++; if (d_rdata[1] !== 32'h1111_2222) $display("FAIL coll_d_rdata got %h want 11112222", d_rdata[1]); else pass_cnt++;
                d_req = 1'b0;
            end
            if (cyc == 4) begin
                total_cnt++; if (mem_addr[1] !== 32'h200) $display("FAIL coll_if_addr got %h want 200", mem_addr[1]); else pass_cnt++;
            end
            if (cyc == 5) if_req = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0104; d_wdata = 32'h0000_00AB; d_size = 2'b01;
        @(negedge clk);
        total_cnt++; if (mem_we[1] !== 1'b1) $display("FAIL store_c1_we got %b want 1", mem_we[1]); else pass_cnt++;
        total_cnt++; if (mem_size[1] !== 2'b01) $display("FAIL store_c1_size got %b want 01", mem_size[1]); else pass_cnt++;
        total_cnt++; if (mem_addr[1] !== 32'h104) $display("FAIL store_c1_addr got %h want 104", mem_addr[1]); else pass_cnt++;
        total_cnt++; if (d_valid[1] !== 1'b0) $display("FAIL store_c1_valid got %b want 0", d_valid[1]); else pass_cnt++;
        d_wdata = 32'h0000_00FF;
        @(negedge clk);
        total_cnt++; if (mem_we[1] !== 1'b0) $display("FAIL store_c2_we got %b want 0", mem_we[1]); else pass_cnt++;
        total_cnt++; if (mem_en[1] !== 1'b1) $display("FAIL store_c2_mem_en got %b want 1", mem_en[1]); else pass_cnt++;
        total_cnt++; if (d_valid[1] !== 1'b1) $display("FAIL store_c2_valid got %b want 1", d_valid[1]); else pass_cnt++;
        total_cnt++; if (mem_wdata[1] !== 32'hAB) $display("FAIL store_c2_wdata got %h want ab", mem_wdata[1]); else pass_cnt++;
        d_req = 1'b0;
        @(negedge clk);
        total_cnt++; if (mem_en[1] !== 1'b0) $display("FAIL store_c3_mem_en got %b want 0", mem_en[1]); else pass_cnt++;
        total_cnt++; if (mem_size[1] !== 2'b01) $display("FAIL store_c3_size_hold got %b want 01", mem_size[1]); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_starvation();
        int grants = 0;
        logic got_if;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
        if_req = 1'b1; if_addr = 32'h0000_0600;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_en[0]) begin
                got_if = (mem_addr[0] == 32'h600);
                total_cnt++;
                if (got_if !== ((grants % 5) == 4))
                    $display("FAIL starve_grant%0d is_fetch got %b want %b", grants, got_if, (grants % 5) == 4);
                else pass_cnt++;
                grants++;
            end
        end
        total_cnt++; if (grants != 10) $display("FAIL starve_grant_count got %0d want 10", grants); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total_cnt++; if (mem_en[2] !== 1'b1) $display("FAIL rmid_c1_mem_en got %b want 1", mem_en[2]); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (mem_en[2] !== 1'b0) $display("FAIL rmid_mem_en got %b want 0", mem_en[2]); else pass_cnt++;
        total_cnt++; if (d_valid[2] !== 1'b0) $display("FAIL rmid_d_valid got %b want 0", d_valid[2]); else pass_cnt++;
        total_cnt++; if (d_rdata[2] !== 32'h0) $display("FAIL rmid_d_rdata got %h want 0", d_rdata[2]); else pass_cnt++;
        total_cnt++; if (d_stall[2] !== 1'b1) $display("FAIL rmid_d_stall got %b want 1", d_stall[2]); else pass_cnt++;
        total_cnt++; if (mem_addr[2] !== 32'h0) $display("FAIL rmid_mem_addr got %h want 0", mem_addr[2]); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (mem_en[2] !== 1'b1) $display("FAIL rmid_regrant got %b want 1", mem_en[2]); else pass_cnt++;
        total_cnt++; if (mem_addr[2] !== 32'h300) $display("FAIL rmid_regrant_addr got %h want 300", mem_addr[2]); else pass_cnt++;
        total_cnt++; if (d_valid[2] !== 1'b0) $display("FAIL rmid_early_valid got %b want 0", d_valid[2]); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (d_valid[2] !== 1'b1) $display("FAIL rmid_final_valid got %b want 1", d_valid[2]); else pass_cnt++;
        d_req = 1'b0;
        do_reset();
    endtask

    task automatic test_flush();
        int valid_cnt = 0;
        int en_cnt = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h0000_0013;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (if_valid[2]) valid_cnt++;
            if (mem_en[2]) en_cnt++;
            if (cyc == 3) begin
                total_cnt++; if (if_valid[2] !== 1'b1) $display("FAIL flush_c3_valid got %b want 1", if_valid[2]); else pass_cnt++;
            end
            if (cyc == 1) if_req = 1'b0;
        end
        total_cnt++; if (valid_cnt != 1) $display("FAIL flush_valid_count got %0d want 1", valid_cnt); else pass_cnt++;
        total_cnt++; if (en_cnt != 3) $display("FAIL flush_mem_en_cycles got %0d want 3", en_cnt); else pass_cnt++;
        total_cnt++; if (if_stall[2] !== 1'b0) $display("FAIL flush_stall got %b want 0", if_stall[2]); else pass_cnt++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_collision();
        test_store_byte();
        test_starvation();
        test_reset_mid_read();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters: the IF-stage fetch port and the MEM-stage load/store port of the pipelined RV32 core.
- Sequences each memory transaction over a fixed latency and returns read data to the owning requester.
- Produces per-port stall signals that the pipeline uses to freeze PC and IF/ID (fetch) or all stages (data).
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  DATA_W  instruction word.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_stall  out  1  if_req & ~if_valid.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_size  in  2  00 = word, 01 = byte, 10 = half (matches the existing memsizesel coding).
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle completion pulse, for both loads and stores.
- d_stall  out  1  d_req & ~d_valid.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_size  out  2  access size; fetch always uses 00.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after address capture.

Behaviour:
States:
- IDLE, GNT_IF, GNT_D.
- 3-bit latency counter lat_cnt.
- Starvation counter starve_cnt, 4 bits.
- Owner attribute registers: addr, we, wdata, size.

Arbitration:
- Evaluated combinationally in IDLE only.
- d_req=1 and not (if_req=1 and starve_cnt==STARVE_MAX): grant data, next state GNT_D.
- Otherwise, if_req=1: grant fetch, next state GNT_IF.
- Neither requesting: stay in IDLE.
- Request attributes are registered at the grant edge. Requesters must hold req until valid; later changes to attributes are ignored.

Issue/complete:
- In GNT_x, mem_en=1 and the mem_* outputs are driven from the registered attributes, held stable for MEM_LAT cycles.
- lat_cnt loads MEM_LAT-1 on grant and decrements each cycle.
- In the GNT_x cycle where lat_cnt==0:
  - x_valid=1.
  - x_rdata = mem_rdata, combinational pass-through.
  - Next state is IDLE.
- mem_we=1 only in the first GNT_D cycle of a store.
- Store d_valid follows the same MEM_LAT timing as a load.
- Throughput: one transaction per MEM_LAT+1 cycles. The IDLE cycle between transactions is mandatory.

Starvation:
- A data grant taken while if_req=1 increments starve_cnt, saturating at STARVE_MAX.
- Any fetch grant clears starve_cnt.
- A data grant with if_req=0 also clears starve_cnt.

Idle outputs:
- In IDLE, mem_en=0, mem_we=0, valids=0.
- mem_addr, mem_wdata and mem_size hold their last value.
- The rdata outputs carry mem_rdata but are qualified only by valid.

Reset (rst=0, any time including mid-transaction):
- Immediately: state=IDLE, lat_cnt=0, starve_cnt=0, attribute registers=0.
- All outputs 0, except the stall signals, which follow their equations with valids=0.
- In-flight transaction is discarded; no valid pulse is issued.
- The first grant is evaluated in the first cycle after rst deasserts.

Simultaneous events:
- A request arriving in the same cycle as another port's valid waits for the next IDLE cycle.
- if_req dropping mid-transaction (pipeline flush):
  - The transaction still completes.
  - if_valid still pulses; the pipeline ignores it.

Decomposition:
- Package arb_pkg holds:
  - the state enum (IDLE, GNT_IF, GNT_D);
  - size codes SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10;
  - MEM_LAT_MAX=4.
- One natural sub-module: arb_lat_counter, a loadable down-counter with a zero flag, reused for lat_cnt.

Test Plan:
1. Fetch only, MEM_LAT=1: if_req=1, if_addr=0x00000010, mem_rdata=0x00A00093 → mem_en in cycle 1 with mem_addr=0x10, if_valid and if_rdata=0x00A00093 in cycle 1, IDLE in cycle 2, if_stall=1 in cycle 2 and 0 in cycle 1.
2. Collision, MEM_LAT=2:
   - Stimulus: if_req and d_req (load, 0x00000100) rise together.
   - Data granted first; d_valid in cycle 2.
   - IDLE in cycle 3; fetch granted in cycle 3; if_valid in cycle 5.
   - if_stall high cycles 1–4.
3. Store byte: d_we=1, d_addr=0x104, d_wdata=0x000000AB, d_size=01 → mem_we=1 for exactly one cycle, mem_size=01, d_valid after MEM_LAT cycles.
4. Starvation, STARVE_MAX=4: d_req and if_req held high continuously → grant sequence D,D,D,D,IF,D,… and starve_cnt returns to 0 after the IF grant.
5. Reset mid-read, MEM_LAT=3: assert rst=0 during the second GNT_D cycle → mem_en=0 immediately, no d_valid; after release with d_req=1, a new grant occurs in the first cycle.
6. Flush: drop if_req mid-fetch → transaction completes, if_valid pulses once, then IDLE with no re-issue.
